// File: rtl/multiword_add_seq.sv
// Streams wide additions through an external N-bit adder, one chunk per cycle, LS chunk first.
// Latency: 1 cycle from input accept to registered result beat.
// Backpressure: in_ready = !out_valid | out_ready; output holds while stalled.
module multiword_add_seq #(
    parameter int N     = 30,
    parameter int WORDS = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_first,
    input  logic         in_last,
    input  logic [N-1:0] in_a,
    input  logic [N-1:0] in_b,
    output logic [N-1:0] add_a,
    output logic [N-1:0] add_b,
    output logic         add_cin,
    input  logic [N-1:0] add_sum,
    input  logic         add_cout,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_sum,
    output logic         out_last,
    output logic         out_cout,
    output logic         out_err
);
    localparam int CW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(WORDS - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state, state_nxt;
    logic          carry_q;
    logic [CW-1:0] cnt;

    logic          accept;
    logic          start;
    logic [CW-1:0] idx;
    logic          forced_last;
    logic          last;
    logic          err;

    assign in_ready = !out_valid | out_ready;
    assign accept   = in_valid & in_ready;
    assign add_a    = in_a;
    assign add_b    = in_b;

    always_comb begin
        state_nxt   = state;
        start       = in_first | (state == IDLE);
        idx         = start ? '0 : cnt;
        forced_last = (idx == LAST_IDX);
        last        = in_last | forced_last;
        add_cin     = start ? 1'b0 : carry_q;
        // A missing first, an abandoned operation, or an overrun all flag the beat.
        err         = (!in_first && state == IDLE) ||
                      ( in_first && state == RUN)  ||
                      (forced_last && !in_last);
        if (accept) begin
            state_nxt = last ? IDLE : RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            carry_q   <= 1'b0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_last  <= 1'b0;
            out_cout  <= 1'b0;
            out_err   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                carry_q   <= last ? 1'b0 : add_cout;
                cnt       <= start ? CW'(1) : cnt + 1'b1;
                out_valid <= 1'b1;
                out_sum   <= add_sum;
                out_last  <= last;
                out_cout  <= last ? add_cout : 1'b0;
                out_err   <= err;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_multiword_add_seq.sv
// Directed bench for multiword_add_seq with N=8, WORDS=4 and a behavioural ripple adder.
module tb_multiword_add_seq;
    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready, in_first, in_last;
    logic [N-1:0] in_a, in_b, add_a, add_b, add_sum, out_sum;
    logic         add_cin, add_cout;
    logic         out_valid, out_ready, out_last, out_cout, out_err;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {8'd0, add_cin};

    multiword_add_seq #(.N(N), .WORDS(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_first(in_first), .in_last(in_last),
        .in_a(in_a), .in_b(in_b),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_sum(add_sum), .add_cout(add_cout),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_last(out_last),
        .out_cout(out_cout), .out_err(out_err)
    );

    typedef struct {
        logic         first;
        logic         last;
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic         cin;
        logic [N-1:0] sum;
        logic         olast;
        logic         cout;
        logic         err;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic apply_chunk(input vec_t v, input string tag);
        @(negedge clk);
        in_valid = 1'b1;
        in_first = v.first;
        in_last  = v.last;
        in_a     = v.a;
        in_b     = v.b;
        #1;
        check({tag, ".in_ready"}, {31'd0, in_ready}, 32'd1);
        check({tag, ".add_cin"}, {31'd0, add_cin}, {31'd0, v.cin});
        @(posedge clk);
        #1;
        check({tag, ".out_valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, ".out_sum"}, {24'd0, out_sum}, {24'd0, v.sum});
        check({tag, ".out_last"}, {31'd0, out_last}, {31'd0, v.olast});
        check({tag, ".out_cout"}, {31'd0, out_cout}, {31'd0, v.cout});
        check({tag, ".out_err"}, {31'd0, out_err}, {31'd0, v.err});
    endtask

    initial begin
        //            first last  a      b      cin  sum    olast cout err
        vecs[0]  = '{1'b1, 1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 8'h01, 8'h00, 1'b1, 8'h02, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 1'b1, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 8'h11, 8'h22, 1'b0, 8'h33, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 8'hF0, 8'h20, 1'b0, 8'h10, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 8'h13, 8'h24, 1'b1, 8'h38, 1'b1, 1'b0, 1'b1};
        vecs[10] = '{1'b0, 1'b0, 8'h05, 8'h06, 1'b0, 8'h0B, 1'b0, 1'b0, 1'b1};
        vecs[11] = '{1'b0, 1'b1, 8'h01, 8'h02, 1'b0, 8'h03, 1'b1, 1'b0, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{1'b1, 1'b1, 8'h01, 8'h01, 1'b0, 8'h02, 1'b1, 1'b0, 1'b1};

        rst = 1'b1; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
        in_a = '0; in_b = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst.out_valid", {31'd0, out_valid}, 32'd0);
        check("rst.out_sum", {24'd0, out_sum}, 32'd0);
        check("rst.out_last", {31'd0, out_last}, 32'd0);
        check("rst.out_cout", {31'd0, out_cout}, 32'd0);
        check("rst.out_err", {31'd0, out_err}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 14; i++) apply_chunk(vecs[i], $sformatf("vec%0d", i));

        // Drain, then stall the output while a carry-chained chunk waits.
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("drain.out_valid", {31'd0, out_valid}, 32'd0);
        apply_chunk('{1'b1, 1'b0, 8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b0, 1'b0, 1'b0}, "bp0");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (i == 0) begin
                out_ready = 1'b0;
                in_first = 1'b0; in_last = 1'b0; in_a = 8'hFF; in_b = 8'hFF;
            end
            #1;
            check("stall.in_ready", {31'd0, in_ready}, 32'd0);
            check("stall.add_cin", {31'd0, add_cin}, 32'd1);
            @(posedge clk);
            #1;
            check("stall.out_valid", {31'd0, out_valid}, 32'd1);
            check("stall.out_sum", {24'd0, out_sum}, 32'hFE);
            check("stall.out_last", {31'd0, out_last}, 32'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        check("release.in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        check("release.out_valid", {31'd0, out_valid}, 32'd1);
        check("release.out_sum", {24'd0, out_sum}, 32'hFF);
        apply_chunk('{1'b0, 1'b1, 8'h00, 8'h00, 1'b1, 8'h01, 1'b1, 1'b0, 1'b0}, "bp2");

        // Reset in the middle of an operation drops it.
        @(negedge clk);
        in_valid = 1'b0;
        apply_chunk('{1'b1, 1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0}, "pre_rst");
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst.out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst.out_sum", {24'd0, out_sum}, 32'd0);
        check("midrst.out_last", {31'd0, out_last}, 32'd0);
        check("midrst.out_cout", {31'd0, out_cout}, 32'd0);
        check("midrst.out_err", {31'd0, out_err}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        apply_chunk('{1'b0, 1'b1, 8'h01, 8'h00, 1'b0, 8'h01, 1'b1, 1'b0, 1'b1}, "post_rst");

        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("final.out_valid", {31'd0, out_valid}, 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
